audio_out_scheduler: RTL and testbench

Sequences sound-out playback for the I2S sender on the NeXT bus clock domain. Buffers stereo samples pushed from the host side in a small FIFO, issues the one-shot start strobe to the sender, and answers each sender sample request with exactly one 32-bit sample. Substitutes silence and counts underruns when the FIFO runs dry. Manages the start/prime/run/drain lifecycle so the sender never sees a half-started stream.

---
 rtl/audio_out_scheduler.sv | 127 ++++++++++++
 tb/tb_audio_out_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/audio_out_scheduler.sv
// Playback sequencer for the I2S sender: buffers host samples, fires the start
// strobe, and answers each sender request with one sample or silence.
module audio_out_scheduler #(
  parameter int DEPTH       = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                       in_clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       host_valid_i,
  input  logic [31:0]                host_data_i,
  output logic                       host_ready_o,
  input  logic                       sample_req_i,
  output logic                       audio_start_out_o,
  output logic                       out_valid_o,
  output logic [31:0]                out_data_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic [7:0]                 underrun_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic            host_ready_q, host_ready_d;
  logic            start_q, start_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [7:0]      und_q, und_d;
  logic [31:0]     mem [DEPTH];

  logic push, serve, pop;

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    level_d      = level_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    start_d      = 1'b0;
    und_d        = und_q;
    host_ready_d = 1'b0;

    push  = host_valid_i && host_ready_q;
    serve = sample_req_i && (state_q == RUN || state_q == DRAIN);
    pop   = serve && (level_q != '0);

    if (push) wr_d = wr_q + AW'(1);
    if (serve) begin
      out_valid_d = 1'b1;
      if (pop) begin
        out_data_d = mem[rd_q];
        rd_d       = rd_q + AW'(1);
      end else begin
        out_data_d = 32'h0;
        // Silence in DRAIN is the expected tail, not an underrun.
        if (state_q == RUN && und_q != 8'hFF) und_d = und_q + 8'd1;
      end
    end
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    case (state_q)
      IDLE:  if (start_i && !stop_i) begin
               state_d = PRIME;
               start_d = 1'b1;
               und_d   = 8'd0;
             end
      PRIME: if (stop_i)                             state_d = IDLE;
             else if (level_q >= LW'(PRIME_LEVEL))   state_d = RUN;
      RUN:   if (stop_i)                             state_d = DRAIN;
      DRAIN: if (level_q == '0)                      state_d = IDLE;
      default:                                       state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end

    // Registered ready must describe the cycle it is visible in.
    host_ready_d = (state_d == PRIME || state_d == RUN) && (level_d < LW'(DEPTH));
  end

  always_ff @(posedge in_clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      host_ready_q <= 1'b0;
      start_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      und_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      level_q      <= level_d;
      host_ready_q <= host_ready_d;
      start_q      <= start_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      und_q        <= und_d;
    end
  end

  always_ff @(posedge in_clk_i) begin
    if (!reset_i && push) mem[wr_q] <= host_data_i;
  end

  assign host_ready_o      = host_ready_q;
  assign audio_start_out_o = start_q;
  assign out_valid_o       = out_valid_q;
  assign out_data_o        = out_data_q;
  assign busy_o            = (state_q != IDLE);
  assign fifo_level_o      = level_q;
  assign underrun_count_o  = und_q;
endmodule

// File: tb/tb_audio_out_scheduler.sv
// Directed bench for audio_out_scheduler; a negedge monitor checks every
// out_valid against a queue of expected samples.
module tb_audio_out_scheduler;
  logic        clk = 1'b0;
  logic        reset, start, stop, host_valid, sample_req;
  logic [31:0] host_data;
  logic        host_ready, audio_start_out, out_valid, busy;
  logic [31:0] out_data;
  logic [2:0]  fifo_level;
  logic [7:0]  underrun_count;

  int n_pass = 0, n_total = 0, start_cnt = 0;
  logic [31:0] expq [$];

  always #5 clk = ~clk;

  audio_out_scheduler #(.DEPTH(4), .PRIME_LEVEL(2)) dut (
    .in_clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop),
    .host_valid_i(host_valid), .host_data_i(host_data), .host_ready_o(host_ready),
    .sample_req_i(sample_req), .audio_start_out_o(audio_start_out),
    .out_valid_o(out_valid), .out_data_o(out_data), .busy_o(busy),
    .fifo_level_o(fifo_level), .underrun_count_o(underrun_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
      else chk("out_data", out_data, expq.pop_front());
    end
    if (audio_start_out === 1'b1) start_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [31:0] e);
    expq.push_back(e);
    sample_req = 1'b1; tick();
    sample_req = 1'b0; tick();
  endtask

  task automatic push(input logic [31:0] d);
    host_valid = 1'b1; host_data = d; tick();
    host_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; host_valid = 1'b0;
    sample_req = 1'b0; host_data = 32'h0;
    tick(); tick();
    chk("rst_ready", {31'd0, host_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    reset = 1'b0; tick();

    // Start, prime with two samples, play them back
    start = 1'b1; tick(); start = 1'b0;
    chk("prime_start_pulse", {31'd0, audio_start_out}, 32'd1);
    chk("prime_busy", {31'd0, busy}, 32'd1);
    chk("prime_ready", {31'd0, host_ready}, 32'd1);
    push(32'h11112222);
    push(32'h33334444);
    chk("prime_level2", {29'd0, fifo_level}, 32'd2);
    tick();
    chk("start_once", start_cnt, 32'd1);
    req(32'h11112222);
    req(32'h33334444);
    chk("und0", {24'd0, underrun_count}, 32'd0);
    chk("level_empty", {29'd0, fifo_level}, 32'd0);

    // Underruns and saturation
    for (int i = 0; i < 3; i++) req(32'h0);
    chk("und3", {24'd0, underrun_count}, 32'd3);
    for (int i = 0; i < 297; i++) req(32'h0);
    chk("und_sat", {24'd0, underrun_count}, 32'd255);

    // Fill to full, then simultaneous push/pop at level 3
    push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_ready", {31'd0, host_ready}, 32'd0);
    req(32'hA1);
    chk("level3", {29'd0, fifo_level}, 32'd3);
    expq.push_back(32'hA2);
    host_valid = 1'b1; host_data = 32'hA5; sample_req = 1'b1; tick();
    host_valid = 1'b0; sample_req = 1'b0;
    chk("pushpop_level", {29'd0, fifo_level}, 32'd3);
    tick();
    req(32'hA3);

    // Stop at level 2 -> drain -> idle
    stop = 1'b1; tick(); stop = 1'b0;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_ready", {31'd0, host_ready}, 32'd0);
    req(32'hA4);
    req(32'hA5);
    chk("drain_idle", {31'd0, busy}, 32'd0);
    sample_req = 1'b1; tick(); sample_req = 1'b0; tick();
    chk("drain_und_hold", {24'd0, underrun_count}, 32'd255);

    // Stop during prime; start+stop from idle
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_und_clr", {24'd0, underrun_count}, 32'd0);
    push(32'hB0);
    chk("prime_level1", {29'd0, fifo_level}, 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("pstop_busy", {31'd0, busy}, 32'd0);
    chk("pstop_level", {29'd0, fifo_level}, 32'd0);
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", {31'd0, busy}, 32'd0);
    chk("ss_start", {31'd0, audio_start_out}, 32'd0);
    tick();
    chk("start_cnt2", start_cnt, 32'd2);

    // Reset mid-run with a request on the same edge
    start = 1'b1; tick(); start = 1'b0;
    push(32'hC1); push(32'hC2); push(32'hC3);
    chk("run_level3", {29'd0, fifo_level}, 32'd3);
    req(32'hC1);
    reset = 1'b1; sample_req = 1'b1; tick(); sample_req = 1'b0;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_data", out_data, 32'd0);
    chk("mr_level", {29'd0, fifo_level}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, host_ready}, 32'd0);
    chk("mr_start", {31'd0, audio_start_out}, 32'd0);
    reset = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("post_rst_und", {24'd0, underrun_count}, 32'd0);
    chk("post_rst_level", {29'd0, fifo_level}, 32'd0);
    tick();
    chk("start_cnt3", start_cnt, 32'd4);
    chk("pending_expect", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
